// File: rtl/fetch_instr_queue_pkg.sv
// Shared fetch-queue types and constants: entry layout, fetch width and PC width.
package fetch_instr_queue_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned FETCH_WIDTH = 2;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } fq_entry_t;

  function automatic logic [1:0] lane_popcount(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/fq_storage_ram.sv
// Entry array for the fetch queue: two write ports, two asynchronous read ports.
module fq_storage_ram
  import fetch_instr_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = INSTR_WIDTH + ADDR_WIDTH,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic [FETCH_WIDTH-1:0] we_i,
  input  logic [PW-1:0]          waddr_i [FETCH_WIDTH],
  input  logic [WIDTH-1:0]       wdata_i [FETCH_WIDTH],
  input  logic [PW-1:0]          raddr_i [FETCH_WIDTH],
  output logic [WIDTH-1:0]       rdata_o [FETCH_WIDTH]
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (we_i[k]) begin
        mem_q[waddr_i[k]] <= wdata_i[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      rdata_o[k] = mem_q[raddr_i[k]];
    end
  end

endmodule

// File: rtl/fetch_instr_queue.sv
// Decoupling queue between 2-wide fetch and 2-wide decode; compacts pushes, retires in order.
module fetch_instr_queue
  import fetch_instr_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = ADDR_WIDTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [31:0]            in_instr  [FETCH_WIDTH],
  input  logic [FETCH_WIDTH-1:0] in_valid,
  input  logic [AW-1:0]          in_pc     [FETCH_WIDTH],
  output logic                   in_ready,
  output logic [31:0]            dec_instr [FETCH_WIDTH],
  output logic [FETCH_WIDTH-1:0] dec_valid,
  output logic [AW-1:0]          dec_pc    [FETCH_WIDTH],
  input  logic [FETCH_WIDTH-1:0] dec_ready,
  output logic [CW-1:0]          count
);

  localparam int unsigned EW = 32 + AW;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic                   push_en;
  logic [1:0]             n_push, n_pop;
  logic                   pop0, pop1;
  logic [FETCH_WIDTH-1:0] we;
  logic [PW-1:0]          waddr [FETCH_WIDTH];
  logic [EW-1:0]          wdata [FETCH_WIDTH];
  logic [PW-1:0]          raddr [FETCH_WIDTH];
  logic [EW-1:0]          rdata [FETCH_WIDTH];

  // Depends on registered occupancy only, so decode/flush never feed back into fetch.
  assign in_ready     = (count_q <= CW'(DEPTH - 2));
  assign dec_valid[0] = (count_q >= CW'(1));
  assign dec_valid[1] = (count_q >= CW'(2));
  assign count        = count_q;

  always_comb begin
    push_en  = in_ready & ~flush;
    we       = '0;
    waddr[0] = wr_ptr_q;
    waddr[1] = wr_ptr_q + PW'(1);
    // A lone lane-1 instruction is compacted into the lane-0 write slot.
    wdata[0] = in_valid[0] ? {in_instr[0], in_pc[0]} : {in_instr[1], in_pc[1]};
    wdata[1] = {in_instr[1], in_pc[1]};
    n_push   = 2'd0;
    if (push_en) begin
      we[0]  = |in_valid;
      we[1]  = &in_valid;
      n_push = lane_popcount(in_valid);
    end

    pop0  = dec_valid[0] & dec_ready[0];
    pop1  = pop0 & dec_valid[1] & dec_ready[1];
    n_pop = {1'b0, pop0} + {1'b0, pop1};

    raddr[0] = rd_ptr_q;
    raddr[1] = rd_ptr_q + PW'(1);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(n_pop);
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      count_d  = count_q + CW'(n_push) - CW'(n_pop);
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fq_storage_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_storage (
    .clk_i   (sys_clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      dec_instr[k] = rdata[k][EW-1:AW];
      dec_pc[k]    = rdata[k][AW-1:0];
    end
  end

`ifndef SYNTHESIS
  count_le_depth: assert property (@(posedge sys_clk) disable iff (!reset)
    count_q <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench for fetch_instr_queue: a queue model tracks accepted entries in order.
module tb_fetch_instr_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [31:0]   in_instr  [2];
  logic [1:0]    in_valid;
  logic [AW-1:0] in_pc     [2];
  logic          in_ready;
  logic [31:0]   dec_instr [2];
  logic [1:0]    dec_valid;
  logic [AW-1:0] dec_pc    [2];
  logic [1:0]    dec_ready;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  always #5 sys_clk = ~sys_clk;

  fetch_instr_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .flush     (flush),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .dec_instr (dec_instr),
    .dec_valid (dec_valid),
    .dec_pc    (dec_pc),
    .dec_ready (dec_ready),
    .count     (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [AW-1:0] pc);
    return 32'h0000_0013 | {pc[19:0], 12'h000};
  endfunction

  // Checks outputs against the model, drives one cycle of stimulus, updates the model.
  task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [AW-1:0] p0,
                      input logic [31:0] i1, input logic [AW-1:0] p1,
                      input logic [1:0] rdy, input logic fl);
    int  n;
    logic pop_a, pop_b;
    n = sb.size();
    check_eq("count", 64'(count), 64'(n));
    check_eq("in_ready", 64'(in_ready), 64'(n <= DEPTH - 2));
    check_eq("dec_valid", 64'(dec_valid), {62'd0, n >= 2, n >= 1});
    if (n >= 1) check_eq("dec_lane0", {dec_instr[0], dec_pc[0]}, sb[0]);
    if (n >= 2) check_eq("dec_lane1", {dec_instr[1], dec_pc[1]}, sb[1]);

    in_valid    = v;
    in_instr[0] = i0;
    in_pc[0]    = p0;
    in_instr[1] = i1;
    in_pc[1]    = p1;
    dec_ready   = rdy;
    flush       = fl;

    if (fl) begin
      sb.delete();
    end else begin
      pop_a = (n >= 1) && rdy[0];
      pop_b = pop_a && (n >= 2) && rdy[1];
      if (pop_a) void'(sb.pop_front());
      if (pop_b) void'(sb.pop_front());
      if (n <= DEPTH - 2) begin
        if (v[0]) sb.push_back({i0, p0});
        if (v[1]) sb.push_back({i1, p1});
      end
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid  = 2'b00;
    dec_ready = 2'b00;
    flush     = 1'b0;
  endtask

  task automatic push2(input logic [AW-1:0] pc, input logic [1:0] rdy);
    step(2'b11, instr_of(pc), pc, instr_of(pc + 4), pc + 4, rdy, 1'b0);
  endtask

  task automatic idle(input logic [1:0] rdy);
    step(2'b00, 32'd0, '0, 32'd0, '0, rdy, 1'b0);
  endtask

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    in_valid    = 2'b00;
    dec_ready   = 2'b00;
    in_instr[0] = '0;
    in_instr[1] = '0;
    in_pc[0]    = '0;
    in_pc[1]    = '0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_dec_valid", 64'(dec_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Fill to full with decode stalled.
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 32'h0000_0013, 32'h100, 32'h0010_0093, 32'h104, 2'b00, 1'b0);
    end
    check_eq("full_count", 64'(count), 64'd8);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    check_eq("full_pc0", 64'(dec_pc[0]), 64'h100);
    check_eq("full_pc1", 64'(dec_pc[1]), 64'h104);
    // Push attempts while full (count 8 then 7) must be dropped even with a pop.
    step(2'b11, 32'h1, 32'h900, 32'h2, 32'h904, 2'b01, 1'b0);
    step(2'b11, 32'h1, 32'h900, 32'h2, 32'h904, 2'b01, 1'b0);
    idle(2'b10);
    for (int k = 0; k < 4; k++) idle(2'b11);
    idle(2'b11);

    // Compaction: lone lane-1 push, then a pair, decoding one per cycle.
    step(2'b10, 32'h0, 32'h0, instr_of(32'h200), 32'h200, 2'b01, 1'b0);
    check_eq("compact_pc0", 64'(dec_pc[0]), 64'h200);
    push2(32'h204, 2'b01);
    for (int k = 0; k < 3; k++) idle(2'b01);

    // Wrap: reach count 6 with rd_ptr 6, then sustained push2/pop2.
    step(2'b00, 32'd0, '0, 32'd0, '0, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) push2(32'h400 + 32'(k * 8), 2'b00);
    for (int k = 0; k < 3; k++) idle(2'b11);
    for (int k = 0; k < 3; k++) push2(32'h500 + 32'(k * 8), 2'b00);
    for (int k = 0; k < 4; k++) begin
      push2(32'h600 + 32'(k * 8), 2'b11);
      check_eq("wrap_count", 64'(count), 64'd6);
    end
    for (int k = 0; k < 3; k++) idle(2'b11);
    idle(2'b11);

    // Flush at count 5 alongside push and pop.
    push2(32'h700, 2'b00);
    push2(32'h708, 2'b00);
    step(2'b01, instr_of(32'h710), 32'h710, 32'h0, 32'h0, 2'b00, 1'b0);
    step(2'b11, 32'h5, 32'h720, 32'h6, 32'h724, 2'b11, 1'b1);
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_dec_valid", 64'(dec_valid), 64'd0);
    step(2'b01, instr_of(32'h300), 32'h300, 32'h0, 32'h0, 2'b00, 1'b0);
    check_eq("post_flush_valid", 64'(dec_valid), 64'b01);
    check_eq("post_flush_pc0", 64'(dec_pc[0]), 64'h300);
    idle(2'b11);

    // Asynchronous reset between edges at count 4.
    push2(32'h800, 2'b00);
    push2(32'h808, 2'b00);
    check_eq("pre_rst_count", 64'(count), 64'd4);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_dec_valid", 64'(dec_valid), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    idle(2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
